// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: shared FSM encoding and control/status bit positions for spi_pwm_gen.
package spi_pwm_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} pwm_state_t;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_POL     = 2;
   localparam int CTRL_IRQ_CLR = 3;
   localparam int CTRL_IRQ_EN  = 4;
   localparam int STAT_RUNNING = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_IRQ     = 2;
   localparam int STAT_WRAP    = 3;
endpackage

// File: rtl/spi_pwm_prescaler.sv
// spi_pwm_prescaler: tick every limit+1 enabled clocks; clr parks the counter at 0.
module spi_pwm_prescaler #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             clr,
   input  logic [WIDTH-1:0] limit,
   output logic             tick
);
   logic [WIDTH-1:0] pre_q, pre_d;
   always_comb begin
      tick  = ena && !clr && (pre_q == limit);
      pre_d = (clr || tick) ? '0 : pre_q + WIDTH'(1);
   end
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) pre_q <= '0;
      else if (ena) pre_q <= pre_d;
endmodule

// File: rtl/spi_pwm_gen.sv
// spi_pwm_gen: double-buffered single-channel PWM behind the SPI register bank.
// Define SPI_PWM_IRQ_EN to add the irq_pend flag and the irq output.
module spi_pwm_gen
   import spi_pwm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic [WIDTH-1:0] cfg_ctrl,
   input  logic [WIDTH-1:0] cfg_prescale,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [WIDTH-1:0] cfg_duty,
   output logic             pwm_out,
`ifdef SPI_PWM_IRQ_EN
   output logic             irq,
`endif
   output logic [WIDTH-1:0] status
);
   pwm_state_t       state_q, state_d;
   logic [WIDTH-1:0] pre_sh_q, pre_sh_d, per_sh_q, per_sh_d, duty_sh_q, duty_sh_d, cnt_q, cnt_d;
   logic [4:0]       wrap_q, wrap_d;
   logic             done_q, done_d, pwm_q, pwm_d;
   logic             en, pol, tick, wrap_evt, irq_pend;

   spi_pwm_prescaler #(.WIDTH(WIDTH)) u_pre (
      .clk  (clk),
      .rstb (rstb),
      .ena  (ena),
      .clr  (state_q != RUN),
      .limit(pre_sh_q),
      .tick (tick)
   );

   always_comb begin
      en        = cfg_ctrl[CTRL_EN];
      pol       = cfg_ctrl[CTRL_POL];
      state_d   = state_q;
      pre_sh_d  = pre_sh_q;
      per_sh_d  = per_sh_q;
      duty_sh_d = duty_sh_q;
      cnt_d     = cnt_q;
      wrap_d    = wrap_q;
      done_d    = done_q;
      pwm_d     = pol;
      wrap_evt  = 1'b0;
      case (state_q)
         IDLE: if (en) begin
            state_d   = RUN;
            pre_sh_d  = cfg_prescale;
            per_sh_d  = cfg_period;
            duty_sh_d = cfg_duty;
            cnt_d     = '0;
         end
         // EN low leaves RUN without any period-end side effects
         RUN: if (!en) state_d = IDLE;
         else begin
            pwm_d = (cnt_q < duty_sh_q) ^ pol;
            if (tick) begin
               wrap_evt = cnt_q == per_sh_q;
               cnt_d    = wrap_evt ? '0 : cnt_q + WIDTH'(1);
               if (wrap_evt) begin
                  pre_sh_d  = cfg_prescale;
                  per_sh_d  = cfg_period;
                  duty_sh_d = cfg_duty;
                  wrap_d    = wrap_q + 5'd1;
                  if (cfg_ctrl[CTRL_ONESHOT]) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         DONE: if (!en) begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         state_q   <= IDLE;
         pre_sh_q  <= '0;
         per_sh_q  <= '0;
         duty_sh_q <= '0;
         cnt_q     <= '0;
         wrap_q    <= '0;
         done_q    <= 1'b0;
         pwm_q     <= 1'b0;
      end else if (ena) begin
         state_q   <= state_d;
         pre_sh_q  <= pre_sh_d;
         per_sh_q  <= per_sh_d;
         duty_sh_q <= duty_sh_d;
         cnt_q     <= cnt_d;
         wrap_q    <= wrap_d;
         done_q    <= done_d;
         pwm_q     <= pwm_d;
      end

`ifdef SPI_PWM_IRQ_EN
   logic irq_pend_q, irq_pend_d, irq_clr_q, unused_ctrl;
   // set beats a simultaneous IRQ_CLR rising edge
   always_comb
      irq_pend_d = (wrap_evt && cfg_ctrl[CTRL_IRQ_EN]) ? 1'b1 :
                   (cfg_ctrl[CTRL_IRQ_CLR] && !irq_clr_q) ? 1'b0 : irq_pend_q;
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         irq_pend_q <= 1'b0;
         irq_clr_q  <= 1'b0;
      end else if (ena) begin
         irq_pend_q <= irq_pend_d;
         irq_clr_q  <= cfg_ctrl[CTRL_IRQ_CLR];
      end
   assign irq         = irq_pend_q;
   assign irq_pend    = irq_pend_q;
   assign unused_ctrl = ^cfg_ctrl[WIDTH-1:5];
`else
   logic unused_ctrl;
   assign irq_pend    = 1'b0;
   assign unused_ctrl = ^cfg_ctrl[WIDTH-1:3];
`endif

   assign pwm_out = pwm_q;
   assign status  = WIDTH'({wrap_q, irq_pend, done_q, state_q == RUN});
endmodule

// File: tb/tb_spi_pwm_gen.sv
// tb_spi_pwm_gen: directed stimulus queues expected outputs; a monitor pops and compares them.
module tb_spi_pwm_gen;
`ifdef SPI_PWM_IRQ_EN
   localparam bit HAS_IRQ = 1'b1;
   logic irq;
`else
   localparam bit HAS_IRQ = 1'b0;
`endif
   logic       clk = 1'b0, rstb = 1'b0, ena = 1'b1;
   logic [7:0] ctrl = 8'h00, pre = 8'h00, per = 8'h00, duty = 8'h00;
   logic       pwm;
   logic [7:0] status;

   typedef struct {
      logic       pwm;
      logic [7:0] stat;
      logic [7:0] mask;
      string      name;
   } exp_t;
   exp_t q[$];
   int passed = 0, total = 0;

   spi_pwm_gen #(.WIDTH(8)) dut (
      .clk         (clk),
      .rstb        (rstb),
      .ena         (ena),
      .cfg_ctrl    (ctrl),
      .cfg_prescale(pre),
      .cfg_period  (per),
      .cfg_duty    (duty),
      .pwm_out     (pwm),
`ifdef SPI_PWM_IRQ_EN
      .irq         (irq),
`endif
      .status      (status)
   );

   always #5 clk = ~clk;

   initial forever begin
      exp_t e;
      @(posedge clk or negedge rstb);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (pwm === e.pwm) passed++;
         else $display("FAIL %s pwm_out got %0b want %0b", e.name, pwm, e.pwm);
         total++;
         if ((status & e.mask) === (e.stat & e.mask)) passed++;
         else $display("FAIL %s status got %02h want %02h (mask %02h)", e.name, status, e.stat, e.mask);
`ifdef SPI_PWM_IRQ_EN
         if (e.mask[2]) begin
            total++;
            if (irq === e.stat[2]) passed++;
            else $display("FAIL %s irq got %0b want %0b", e.name, irq, e.stat[2]);
         end
`endif
      end
   end

   function automatic logic [7:0] st(input int w, input bit ip, input bit d, input bit r);
      return {w[4:0], ip & HAS_IRQ, d, r};
   endfunction

   // prescale=0, period=3, duty=2 waveform, i clocks after EN is sampled
   function automatic logic pat(input int i);
      return i != 0 && ((i - 1) % 4) < 2;
   endfunction

   task automatic step(input logic p, input logic [7:0] s, input logic [7:0] m, input string n);
      q.push_back('{p, s, m, n});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      ctrl = 8'h00;
      ena  = 1'b1;
      rstb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstb = 1'b1;
   endtask

   task automatic cfg(input logic [7:0] c, input logic [7:0] p, input logic [7:0] r, input logic [7:0] d);
      ctrl = c;
      pre  = p;
      per  = r;
      duty = d;
   endtask

   initial begin
      logic [8:0] pv;
      int j;
      @(negedge clk);
      step(1'b0, 8'h00, 8'hFF, "reset");
      rstb = 1'b1;

      cfg(8'h01, 8'd0, 8'd3, 8'd2);
      for (int i = 0; i <= 12; i++) step(pat(i), st(i / 4, 0, 0, 1), 8'hFF, "basic");
      ctrl = 8'h00;
      step(1'b0, st(3, 0, 0, 0), 8'hFF, "en_off");

      do_reset();
      cfg(8'h01, 8'd0, 8'd3, 8'd0);
      for (int i = 0; i <= 8; i++) step(1'b0, 8'h01, 8'h07, "duty0");

      do_reset();
      cfg(8'h01, 8'd0, 8'd3, 8'd9);
      for (int i = 0; i <= 8; i++) step(i != 0, 8'h01, 8'h07, "duty_gt_period");

      do_reset();
      cfg(8'h05, 8'd0, 8'd3, 8'd0);
      for (int i = 0; i <= 8; i++) step(1'b1, 8'h01, 8'h07, "pol_duty0");

      do_reset();
      cfg(8'h01, 8'd0, 8'd0, 8'd1);
      for (int i = 0; i <= 8; i++) step(i != 0, st(i, 0, 0, 1), 8'hFF, "period0");

      do_reset();
      cfg(8'h03, 8'd2, 8'd1, 8'd1);
      for (int i = 0; i <= 7; i++) step(i >= 1 && i <= 3, i < 6 ? 8'h01 : 8'h02, 8'h07, "oneshot");
      ctrl = 8'h00;
      step(1'b0, 8'h00, 8'h07, "oneshot_drop_en");

      do_reset();
      cfg(8'h01, 8'd0, 8'd3, 8'd1);
      pv = 9'b011100010;
      for (int i = 0; i <= 8; i++) begin
         if (i == 2) duty = 8'd3;
         step(pv[i], st(i / 4, 0, 0, 1), 8'hFF, "duty_shadow");
      end

      do_reset();
      cfg(8'h11, 8'd0, 8'd3, 8'd2);
      for (int i = 0; i <= 17; i++) begin
         ctrl = (i < 6) ? 8'h11 : (i < 10) ? 8'h19 : (i < 13) ? 8'h09 : (i < 16) ? 8'h11 : 8'h19;
         step(pat(i), st(i / 4, !(i < 4 || i == 6 || i == 7), 0, 1), 8'hFF, "irq");
      end

      do_reset();
      cfg(8'h01, 8'd0, 8'd3, 8'd2);
      for (int i = 0; i <= 12; i++) begin
         ena = !(i >= 3 && i < 8);
         j = (i < 3) ? i : (i < 8) ? 2 : i - 5;
         step(pat(j), st(j / 4, 0, 0, 1), 8'hFF, "freeze");
      end

      do_reset();
      cfg(8'h01, 8'd0, 8'd3, 8'd2);
      for (int i = 0; i <= 5; i++) step(pat(i), st(i / 4, 0, 0, 1), 8'hFF, "prerun");
      q.push_back('{1'b0, 8'h00, 8'hFF, "async_reset"});
      #2 rstb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstb = 1'b1;
      for (int i = 0; i <= 5; i++) step(pat(i), st(i / 4, 0, 0, 1), 8'hFF, "restart");

      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain left %0d want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/spi_pwm_gen.md
# spi_pwm_gen

Single-channel PWM generator that sits directly downstream of the SPI register bank. It consumes four 8-bit configuration registers (control, prescaler, period, duty) and drives one PWM pin. It returns an 8-bit status byte that feeds the bank's status input. Configuration is double-buffered, so SPI writes never produce a glitched period.

## Interface
- `WIDTH`, 8: width of every config/status register and internal counter.
- `clk` input 1: system clock; all logic on posedge.
- `rstb` input 1: reset, asynchronous, active-low.
- `ena` input 1: global enable; when low, all state (counters, FSM, flags, outputs) holds.
- `cfg_ctrl` input WIDTH: control bits:
  - [0] EN: run.
  - [1] ONESHOT: single period then stop.
  - [2] POL: invert output.
  - [3] IRQ_CLR: clears the IRQ flag on its rising edge.
  - [4] IRQ_EN: allow the IRQ flag to set.
  - [7:5] reserved, ignored.
- `cfg_prescale` input WIDTH: tick every `cfg_prescale`+1 enabled clocks.
- `cfg_period` input WIDTH: period length is `cfg_period`+1 ticks.
- `cfg_duty` input WIDTH: number of active ticks per period.
- `pwm_out` output 1: registered PWM output; reset 0.
- `irq` output 1: registered interrupt; reset 0. Present only with `SPI_PWM_IRQ_EN`.
- `status` output WIDTH: `{wrap_cnt[4:0], irq_pend, done, running}`; reset 0.

## Operation
- FSM states:
  - IDLE (reset state): `pwm_out` = POL. If EN=1, go to RUN. On entry to RUN: load the shadow registers (prescale, period, duty) from the cfg inputs, clear the tick counter `pre` and the period counter `cnt`.
  - RUN: `pre` counts 0..shadow_prescale. When `pre` equals shadow_prescale, a tick occurs: `pre` returns to 0 and `cnt` advances. `cnt` counts 0..shadow_period.
    - Period end is a tick taken while `cnt` == shadow_period.
    - At period end: `cnt` → 0, shadows reload from the cfg inputs, `wrap_cnt` increments (5-bit, wraps 31→0), and if IRQ_EN=1 then `irq_pend` is set.
    - At period end with ONESHOT=1: go to DONE instead and set `done`.
    - If EN=0: go to IDLE next clock, with no period-end side effects.
  - DONE: `pwm_out` = POL (inactive). If EN=0, go to IDLE and clear `done`.
- Raw output is high when `cnt` < shadow_duty.
  - duty=0: always low.
  - duty > period: always high.
  - period=0: every tick is a period end.
  - `pwm_out` = raw XOR POL in RUN.
- `running` = (state==RUN).
- Writes to `cfg_prescale`/`cfg_period`/`cfg_duty` during RUN take effect only at the next period end or the next IDLE→RUN entry.
- `irq_pend`:
  - Set by a period end (IRQ_EN=1).
  - Cleared by a registered rising-edge detect of IRQ_CLR.
  - If set and clear occur in the same cycle, set wins.
  - Clearing IRQ_EN does not clear a pending flag.
- `ena`=0 freezes everything, including the IRQ_CLR edge-detect register. An edge that occurs while `ena`=0 is seen when `ena` returns, if the level persists.
- Reset mid-run: all outputs are 0 immediately (asynchronous); the FSM is in IDLE; shadows and counters are 0.

## Timing
- EN sampled high at edge k: state=RUN after edge k.
- `pwm_out` reflects `cnt`=0 after edge k+1 (2-clock latency from EN to first active level).
- With `ena` held high, each count lasts `shadow_prescale`+1 clocks. The period is (period+1)·(prescale+1) clocks.
- `irq_pend`/`irq`/`wrap_cnt` update on the same edge that wraps `cnt`. `done` updates on the edge entering DONE.
- EN falling: `running` drops one clock after EN is sampled low. `pwm_out` returns to POL on that same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SPI_PWM_IRQ_EN` defined:
  - The `irq` port exists.
  - `irq` = `irq_pend` registered, i.e. it follows `irq_pend` by 0 cycles from the same flop, output directly.
- Undefined:
  - No `irq` port.
  - `irq_pend` logic is removed; `status[2]` is tied to 0.
  - IRQ_EN and IRQ_CLR are ignored.

## Structure
- Package `spi_pwm_pkg` holds:
  - FSM enum `pwm_state_t` {IDLE, RUN, DONE}.
  - Control bit-index localparams: CTRL_EN=0, CTRL_ONESHOT=1, CTRL_POL=2, CTRL_IRQ_CLR=3, CTRL_IRQ_EN=4.
  - Status bit-index localparams.
- Sub-module `spi_pwm_prescaler`:
  - Holds the `pre` counter and tick generation.
  - Inputs: `clk`, `rstb`, `ena`, `clr`, `limit`.
  - Output: `tick`.
- The top-level module holds the FSM, shadows, `cnt`, flags, and the output stage.

## Test plan
- prescale=0, period=3, duty=2, EN=1 → `pwm_out` repeats 1,1,0,0 starting 2 clocks after EN. `wrap_cnt` increments every 4 clocks.
- Edge cases:
  - duty=0 → constant 0.
  - duty=9 with period=3 → constant 1.
  - POL=1 with duty=0 → constant 1.
  - period=0 → `wrap_cnt` increments every tick.
- prescale=2, period=1, duty=1, ONESHOT=1 → `pwm_out` high 3 clocks, low 3 clocks, then `done`=1 and `running`=0. Dropping EN clears `done`.
- Duty changed 1→3 mid-period (period=3) → the current period keeps duty=1; the next period shows duty=3.
- IRQ_EN=1:
  - At the first wrap, `status[2]`=1 and `irq`=1.
  - Toggling IRQ_CLR 0→1 clears both.
  - Holding IRQ_CLR at 1 does not block the next wrap from setting the flag.
- Freeze and reset:
  - `ena`=0 for 5 clocks mid-period → the waveform stretches by exactly 5 clocks.
  - `rstb` asserted mid-run → all outputs 0 asynchronously; after release with EN=1, a fresh period restarts.
